// File: rtl/uart_tx_fifo_if.sv
// Byte write port of uart_tx_fifo: producer drives din/din_vld, the FIFO returns rdy/ovf.
interface uart_tx_fifo_if;
   logic [7:0] din;
   logic       din_vld;
   logic       rdy;
   logic       ovf;

   modport master (output din, output din_vld, input rdy, input ovf);
   modport slave  (input din, input din_vld, output rdy, output ovf);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1) fed by a DEPTH x 8 byte FIFO; back-to-back frames when data is queued.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx_fifo #(
   parameter int unsigned CLK_FREQ = 25_000_000,
   parameter int unsigned BAUD     = 9600,
   parameter int unsigned DEPTH    = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   uart_tx_fifo_if.slave wr,
   output logic          busy,
   output logic          uart_tx
);

   localparam int unsigned BaudDiv = CLK_FREQ / BAUD;
   localparam int unsigned PtrW    = $clog2(DEPTH);
   localparam int unsigned CntW    = PtrW + 1;
   localparam int unsigned BcW     = $clog2(BaudDiv);

   localparam logic [CntW-1:0] Full     = CntW'(DEPTH);
   localparam logic [BcW-1:0]  BaudLast = BcW'(BaudDiv - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

   logic [7:0]      mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] cnt_q;
   logic            ovf_q;
   logic            rdy, wr_en, pop;
   logic [7:0]      head;

   state_e          state_q, state_d;
   logic [BcW-1:0]  baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic            bit_end;

   // rdy is taken from the registered count, so a pop cannot rescue a write into a full FIFO
   assign rdy   = (cnt_q != Full);
   assign wr_en = wr.din_vld & rdy;
   assign head  = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= wr.din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         ovf_q <= wr.din_vld & ~rdy;
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         case ({wr_en, pop})
            2'b10:   cnt_q <= cnt_q + CntW'(1);
            2'b01:   cnt_q <= cnt_q - CntW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

`ifdef UART_TX_PARITY_EN
   logic par_q, par_d;

   assign par_d = pop ? ^head : par_q;
`endif

   assign bit_end = (baud_q == BaudLast);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + BcW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            baud_d = '0;
            if (cnt_q != '0) begin
               pop     = 1'b1;
               shift_d = head;
               state_d = StStart;
            end
         end
         StStart: begin
            if (bit_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = StData;
            end
         end
         StData: begin
            if (bit_end) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (bit_end) begin
               baud_d  = '0;
               state_d = StStop;
            end
         end
`endif
         StStop: begin
            if (bit_end) begin
               baud_d = '0;
               // Queued data goes straight into the next start bit with no idle gap
               if (cnt_q != '0) begin
                  pop     = 1'b1;
                  shift_d = head;
                  state_d = StStart;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      tx_d = 1'b1;
      unique case (state_q)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
         StParity: tx_d = par_q;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign busy    = (state_q != StIdle) || (cnt_q != '0);
   assign uart_tx = tx_q;
   assign wr.rdy  = rdy;
   assign wr.ovf  = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: line monitor feeds a frame queue checked against expected bytes.
module tb_uart_tx_fifo;

   localparam int unsigned ClkFreq = 1000;
   localparam int unsigned Baud    = 100;
   localparam int unsigned Depth   = 4;
   localparam int          BaudDiv = 10;
`ifdef UART_TX_PARITY_EN
   localparam bit ParityEn = 1'b1;
`else
   localparam bit ParityEn = 1'b0;
`endif
   localparam int FrameBits = ParityEn ? 11 : 10;
   localparam int FrameClks = FrameBits * BaudDiv;
   localparam int MonSpan   = (FrameBits - 1) * BaudDiv + BaudDiv / 2;

   typedef struct {
      logic [7:0] data;
      logic       par;
      bit         ok;
      int         fall;
   } frame_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic busy;
   logic uart_tx;

   frame_t     obs_q[$];
   logic [7:0] exp_q[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc    = 0;

   uart_tx_fifo_if wr_if ();

   uart_tx_fifo #(
      .CLK_FREQ (ClkFreq),
      .BAUD     (Baud),
      .DEPTH    (Depth)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr      (wr_if),
      .busy    (busy),
      .uart_tx (uart_tx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Line decoder: samples mid-bit on negedges, drops frames cut short by reset
   initial begin : monitor
      frame_t f;
      bit     abort;
      int     b;
      forever begin
         @(negedge clk);
         if (!rst_n && uart_tx === 1'b0) begin
            f.data = '0;
            f.par  = 1'b0;
            f.ok   = 1'b1;
            f.fall = cyc;
            abort  = 1'b0;
            for (int k = 0; k < MonSpan; k++) begin
               if (k > 0) @(negedge clk);
               if (rst_n) abort = 1'b1;
               if (k % BaudDiv == BaudDiv / 2 - 1) begin
                  b = k / BaudDiv;
                  if (b == 0) begin
                     if (uart_tx !== 1'b0) f.ok = 1'b0;
                  end else if (b <= 8) begin
                     f.data[b-1] = uart_tx;
                  end else if (ParityEn && b == 9) begin
                     f.par = uart_tx;
                  end else if (uart_tx !== 1'b1) begin
                     f.ok = 1'b0;
                  end
               end
            end
            if (!abort) obs_q.push_back(f);
         end
      end
   end

   initial begin : watchdog
      #500_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic send_byte(input logic [7:0] b);
      wr_if.din     = b;
      wr_if.din_vld = 1'b1;
      exp_q.push_back(b);
      @(posedge clk);
      @(negedge clk);
      wr_if.din_vld = 1'b0;
   endtask

   task automatic wait_obs(input int n, output bit to);
      int k = 0;
      while (obs_q.size() < n && k < (n + 1) * FrameClks + 50) begin
         @(negedge clk);
         k++;
      end
      to = (obs_q.size() < n);
   endtask

   task automatic wait_idle(output bit to);
      int k = 0;
      while (busy !== 1'b0 && k < 20 * FrameClks) begin
         @(negedge clk);
         k++;
      end
      to = (busy !== 1'b0);
      repeat (BaudDiv) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n         = 1'b1;
      wr_if.din     = '0;
      wr_if.din_vld = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b required 1", uart_tx); end
      checks++; if (wr_if.rdy !== 1'b1) begin errors++; $display("FAIL rst_rdy: got %b required 1", wr_if.rdy); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
      checks++; if (wr_if.ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b required 0", wr_if.ovf); end
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL post_rst_tx: got %b required 1", uart_tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy: got %b required 0", busy); end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_single();
      logic [7:0] d = 8'h55;
      logic       exp_bit, got;
      bit         bad, to;
      frame_t     f;
      logic [7:0] e;
      send_byte(d);
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL lat_edge0: got %b required 1", uart_tx); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_accept: got %b required 1", busy); end
      @(negedge clk);
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL lat_edge1: got %b required 1", uart_tx); end
      @(negedge clk);
      checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL lat_edge2: got %b required 0", uart_tx); end
      for (int b = 0; b < FrameBits; b++) begin
         if (b == 0) exp_bit = 1'b0;
         else if (b <= 8) exp_bit = d[b-1];
         else if (ParityEn && b == 9) exp_bit = ^d;
         else exp_bit = 1'b1;
         bad = 1'b0;
         got = exp_bit;
         for (int s = 0; s < BaudDiv; s++) begin
            if (b != 0 || s != 0) @(negedge clk);
            if (uart_tx !== exp_bit && !bad) begin bad = 1'b1; got = uart_tx; end
            if (b == FrameBits / 2 && s == 0) begin
               checks++;
               if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid: got %b required 1", busy); end
            end
         end
         checks++;
         if (bad) begin errors++; $display("FAIL line_bit%0d: got %b required %b", b, got, exp_bit); end
      end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_end: got %b required 0", busy); end
      wait_obs(1, to);
      checks++;
      if (to) begin
         errors++; $display("FAIL single_frame: got no frame required 1 frame");
      end else begin
         f = obs_q.pop_front(); e = exp_q.pop_front();
         if (f.data !== e || !f.ok) begin
            errors++; $display("FAIL single_data: got %02h ok=%0b required %02h ok=1", f.data, f.ok, e);
         end
      end
      wait_idle(to);
      checks++; if (to) begin errors++; $display("FAIL single_idle: got busy required idle"); end
   endtask

   task automatic test_back_to_back();
      bit         to;
      frame_t     f;
      logic [7:0] e;
      int         fall0;
      send_byte(8'hA3);
      send_byte(8'h0F);
      wait_obs(2, to);
      checks++;
      if (to) begin
         errors++; $display("FAIL b2b_frames: got %0d frames required 2", obs_q.size());
      end else begin
         if (obs_q[1].fall - obs_q[0].fall !== FrameClks) begin
            errors++;
            $display("FAIL b2b_gap: got %0d clocks required %0d", obs_q[1].fall - obs_q[0].fall, FrameClks);
         end
         fall0 = obs_q[0].fall;
         for (int i = 0; i < 2; i++) begin
            f = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (f.data !== e || !f.ok) begin
               errors++; $display("FAIL b2b_data%0d: got %02h ok=%0b required %02h ok=1", i, f.data, f.ok, e);
            end
         end
      end
      wait_idle(to);
      checks++; if (to) begin errors++; $display("FAIL b2b_idle: got busy required idle"); end
   endtask

   task automatic test_overflow();
      int         mcnt = 0;
      bit         acc, to;
      frame_t     f;
      logic [7:0] e;
      for (int i = 0; i < 6; i++) begin
         wr_if.din     = 8'(i + 1);
         wr_if.din_vld = 1'b1;
         acc = (mcnt != Depth);
         checks++;
         if (wr_if.rdy !== acc) begin errors++; $display("FAIL ovf_rdy%0d: got %b required %b", i, wr_if.rdy, acc); end
         if (acc) exp_q.push_back(8'(i + 1));
         // The idle FSM pops the first byte on the edge after it lands
         mcnt = mcnt + (acc ? 1 : 0) - ((i == 1) ? 1 : 0);
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (wr_if.ovf !== !acc) begin errors++; $display("FAIL ovf_pulse%0d: got %b required %b", i, wr_if.ovf, !acc); end
      end
      wr_if.din_vld = 1'b0;
      @(negedge clk);
      checks++; if (wr_if.ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b required 0", wr_if.ovf); end
      wait_obs(5, to);
      checks++;
      if (to) begin
         errors++; $display("FAIL ovf_frames: got %0d frames required 5", obs_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            f = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (f.data !== e || !f.ok) begin
               errors++; $display("FAIL ovf_data%0d: got %02h ok=%0b required %02h ok=1", i, f.data, f.ok, e);
            end
         end
      end
      wait_idle(to);
      checks++;
      if (to || obs_q.size() != 0) begin
         errors++; $display("FAIL ovf_extra: got %0d extra frames busy=%b required 0 idle", obs_q.size(), busy);
      end
   endtask

   task automatic test_full_pop();
      int         mcnt = 0;
      bit         acc, to;
      frame_t     f;
      logic [7:0] e;
      for (int i = 0; i < 5; i++) begin
         wr_if.din     = 8'(8'h11 + i);
         wr_if.din_vld = 1'b1;
         acc = (mcnt != Depth);
         if (acc) exp_q.push_back(8'(8'h11 + i));
         mcnt = mcnt + (acc ? 1 : 0) - ((i == 1) ? 1 : 0);
         @(posedge clk);
         @(negedge clk);
      end
      wr_if.din_vld = 1'b0;
      // Land the next write on the STOP->START pop edge of the first frame
      repeat (FrameClks - 4) @(negedge clk);
      wr_if.din     = 8'hEE;
      wr_if.din_vld = 1'b1;
      checks++; if (wr_if.rdy !== 1'b0) begin errors++; $display("FAIL full_rdy: got %b required 0", wr_if.rdy); end
      @(posedge clk);
      @(negedge clk);
      wr_if.din_vld = 1'b0;
      checks++; if (wr_if.ovf !== 1'b1) begin errors++; $display("FAIL full_ovf: got %b required 1", wr_if.ovf); end
      checks++; if (wr_if.rdy !== 1'b1) begin errors++; $display("FAIL full_rdy_back: got %b required 1", wr_if.rdy); end
      wait_obs(5, to);
      checks++;
      if (to) begin
         errors++; $display("FAIL full_frames: got %0d frames required 5", obs_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            f = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (f.data !== e || !f.ok) begin
               errors++; $display("FAIL full_data%0d: got %02h ok=%0b required %02h ok=1", i, f.data, f.ok, e);
            end
         end
      end
      repeat (2 * FrameClks) @(negedge clk);
      checks++;
      if (obs_q.size() != 0 || busy !== 1'b0) begin
         errors++; $display("FAIL full_dropped: got %0d extra frames busy=%b required 0 idle", obs_q.size(), busy);
      end
   endtask

   task automatic test_reset_midframe();
      int lows = 0;
      send_byte(8'hFF);
      send_byte(8'h00);
      exp_q.delete();
      @(negedge clk);
      checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL mid_start: got %b required 0", uart_tx); end
      // Start bit plus three data bits plus a few clocks puts us inside bit 3
      repeat (3 * BaudDiv + BaudDiv + 3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL mid_tx: got %b required 1", uart_tx); end
      checks++; if (wr_if.rdy !== 1'b1) begin errors++; $display("FAIL mid_rdy: got %b required 1", wr_if.rdy); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b required 0", busy); end
      @(negedge clk);
      rst_n = 1'b0;
      for (int k = 0; k < 3 * FrameClks; k++) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) lows++;
      end
      checks++; if (lows != 0) begin errors++; $display("FAIL mid_quiet: got %0d low samples required 0", lows); end
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL mid_frames: got %0d frames required 0", obs_q.size()); end
      obs_q.delete();
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      bit         to;
      frame_t     f;
      logic [7:0] e;
      send_byte(8'h07);
      send_byte(8'h07);
      wait_obs(2, to);
      checks++;
      if (to) begin
         errors++; $display("FAIL par_frames: got %0d frames required 2", obs_q.size());
      end else begin
         if (obs_q[1].fall - obs_q[0].fall !== 110) begin
            errors++; $display("FAIL par_len: got %0d clocks required 110", obs_q[1].fall - obs_q[0].fall);
         end
         for (int i = 0; i < 2; i++) begin
            f = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (f.data !== e || !f.ok) begin
               errors++; $display("FAIL par_data%0d: got %02h ok=%0b required %02h ok=1", i, f.data, f.ok, e);
            end
            checks++;
            if (f.par !== 1'b1) begin errors++; $display("FAIL par_bit%0d: got %b required 1", i, f.par); end
         end
      end
      wait_idle(to);
      checks++; if (to) begin errors++; $display("FAIL par_idle: got busy required idle"); end
   endtask
`endif

   initial begin : main
      wr_if.din     = '0;
      wr_if.din_vld = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_full_pop();
      test_reset_midframe();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

UART transmitter with byte FIFO: the return path for the serial control link, sending 8N1 (optionally 8E1) frames on the `uart_tx` pin. Runs in the 25 MHz pixel-derived clock domain alongside the receive chain. Buffers bytes so status/echo producers (e.g. control register readback, hex-to-ASCII formatter) can burst without waiting on the line.

## Interface

Parameters:
- `CLK_FREQ`, 25_000_000: clock frequency in Hz.
- `BAUD`, 9600: line rate; `BAUD_DIV = CLK_FREQ/BAUD` (integer, truncated), must be ≥ 2.
- `DEPTH`, 16: FIFO entries; power of 2, ≥ 2.

Ports:
- `clk`  in  1  system clock (`clk_25M` at top level).
- `rst_n`  in  1  reset. **Synchronous, active-high (1 = reset)**; port name kept for codebase consistency.
- `din`  in  8  byte to send.
- `din_vld`  in  1  write strobe; a byte is accepted when `din_vld && rdy`.
- `rdy`  out  1  FIFO not full.
- `ovf`  out  1  one-cycle pulse when `din_vld` is high while `rdy` is low; the byte is dropped.
- `busy`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `uart_tx`  out  1  serial output; idle high.

## Operation

- FIFO: `DEPTH` × 8, registered occupancy count `cnt` (0..DEPTH). `rdy = (cnt != DEPTH)`. Write when `din_vld && rdy`. Pop by the FSM.
- Simultaneous write and pop: both happen and `cnt` is unchanged. `rdy` comes from the registered `cnt`, so a write arriving while full is rejected even if a pop occurs in the same cycle; `ovf` pulses.
- Pointers wrap modulo `DEPTH`.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE: if `cnt != 0`, pop the head into a shift register and go to START. Otherwise stay.
  - START: drive 0 for `BAUD_DIV` clocks, then go to DATA.
  - DATA: 8 bits, LSB first, `BAUD_DIV` clocks each. A 3-bit index counts bits. After bit 7, go to PARITY or STOP.
  - STOP: drive 1 for `BAUD_DIV` clocks. Then, if `cnt != 0`, pop and go directly to START (back-to-back, no idle gap). Otherwise go to IDLE.
- Baud counter: counts 0..BAUD_DIV−1 and resets on every state entry. The bit ends when the count reaches BAUD_DIV−1.
- `uart_tx` is registered and driven from the state and shift register.
- `busy = (state != IDLE) || (cnt != 0)`.

## Timing

- Reset values: `uart_tx`=1, `rdy`=1, `busy`=0, `ovf`=0, `cnt`=0, state IDLE, counters 0.
- Reset asserted mid-frame: on the next edge `uart_tx` returns to 1, FIFO contents are discarded, and the partial frame is truncated.
- Latency, idle to start bit:
  - byte accepted at edge N;
  - FSM pops at edge N+1;
  - `uart_tx` falls after edge N+2.
- Frame length: 10×`BAUD_DIV` clocks (11× with parity), measured from the falling edge of the start bit to the end of the stop bit.
- `ovf` is registered: it is high for exactly the cycle after the rejected write.
- `rdy` reasserts on the edge after the pop that takes `cnt` from DEPTH to DEPTH−1.

## Configuration

- `UART_TX_PARITY_EN` defined: PARITY state inserted between DATA and STOP. The bit is driven for `BAUD_DIV` clocks with value even parity = XOR of the 8 data bits. Frame is 11 bits.
- Not defined: PARITY state and logic are absent; frame is 8N1, 10 bits.

## Test plan

Parameters for all scenarios: `CLK_FREQ=1000`, `BAUD=100` (so `BAUD_DIV=10`), `DEPTH=4`.

1. Reset, then write 0x55 once:
   - `uart_tx` falls 2 clocks after acceptance;
   - the line carries 0,1,0,1,0,1,0,1,0,1, each held 10 clocks;
   - `busy` drops after 100 clocks of frame.
2. Write 0xA3 then 0x0F on consecutive cycles:
   - two frames back-to-back, with the stop bit of frame 1 immediately followed by the start bit of frame 2;
   - decoded bytes are 0xA3, 0x0F.
3. Hold `din_vld` for 6 cycles while idle, data 1..6:
   - bytes 1..4 are buffered (one has been popped by then, so 5 is accepted); 6 is dropped;
   - `ovf` pulses once;
   - line sends 1,2,3,4,5.
4. FIFO full, and a write arrives on the same cycle as the STOP→START pop: the write is rejected, `ovf`=1, and `cnt` goes to DEPTH−1.
5. Assert `rst_n`=1 during bit 3 of 0xFF:
   - `uart_tx`=1 on the next edge;
   - `rdy`=1, `busy`=0;
   - no further frame is sent.
6. With `UART_TX_PARITY_EN`, send 0x07: parity bit = 1, the frame lasts 110 clocks, and the stop bit follows the parity bit.
